// File: rtl/video_window_calc_if.sv
// Video window calculator port bundle.
// Master drives geometry and aspect inputs; slave returns the window.
interface video_window_calc_if;
  logic [11:0] HDMI_WIDTH;
  logic [11:0] HDMI_HEIGHT;
  logic [12:0] ARX;
  logic [12:0] ARY;
  logic [11:0] hmin;
  logic [11:0] hmax;
  logic [11:0] vmin;
  logic [11:0] vmax;
  logic        valid;
  logic        upd;

  modport master (
    output HDMI_WIDTH,
    output HDMI_HEIGHT,
    output ARX,
    output ARY,
    input  hmin,
    input  hmax,
    input  vmin,
    input  vmax,
    input  valid,
    input  upd
  );

  modport slave (
    input  HDMI_WIDTH,
    input  HDMI_HEIGHT,
    input  ARX,
    input  ARY,
    output hmin,
    output hmax,
    output vmin,
    output vmax,
    output valid,
    output upd
  );
endinterface

// File: rtl/video_window_calc.sv
// Centred output window from aspect ratio or absolute size.
// Shares one shift-add multiplier and one restoring divider over two passes.
module video_window_calc (
  input  logic               CLK_VIDEO,
  input  logic               reset,
  video_window_calc_if.slave vw
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_MUL,
    S_DIV,
    S_CMP,
    S_CLAMP,
    S_CENTER,
    S_PUBLISH
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] w_s_q, w_s_d;
  logic [11:0] h_s_q, h_s_d;
  logic [12:0] arx_s_q, arx_s_d;
  logic [12:0] ary_s_q, ary_s_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        pass_q, pass_d;
  logic [23:0] prod_q, prod_d;
  logic [12:0] rem_q, rem_d;
  logic [11:0] w_q, w_d;
  logic [11:0] h_q, h_d;
  logic [11:0] hmin_c_q, hmin_c_d;
  logic [11:0] hmax_c_q, hmax_c_d;
  logic [11:0] vmin_c_q, vmin_c_d;
  logic [11:0] vmax_c_q, vmax_c_d;
  logic [11:0] hmin_q, hmin_d;
  logic [11:0] hmax_q, hmax_d;
  logic [11:0] vmin_q, vmin_d;
  logic [11:0] vmax_q, vmax_d;
  logic        valid_q, valid_d;
  logic        upd_q, upd_d;

  logic        changed;
  logic [11:0] mul_a;
  logic [11:0] mul_b;
  logic [11:0] dvs;
  logic [23:0] add_t;
  logic [12:0] rem_sh;
  logic        ge;
  logic [23:0] quo;
  logic [11:0] wc;
  logic [11:0] w_min;
  logic [11:0] h_min;
  logic [11:0] hdiff;
  logic [11:0] vdiff;
  logic [11:0] hmin_c;
  logic [11:0] vmin_c;

  function automatic logic [11:0] sat12(input logic [23:0] v);
    return (|v[23:12]) ? 12'hFFF : v[11:0];
  endfunction

  // Pass 0 computes H*ARX/ARY; pass 1 computes W*ARY/ARX.
  always_comb begin
    changed = {vw.HDMI_WIDTH, vw.HDMI_HEIGHT, vw.ARX, vw.ARY}
           != {w_s_q, h_s_q, arx_s_q, ary_s_q};
    mul_a   = pass_q ? w_s_q : h_s_q;
    mul_b   = pass_q ? ary_s_q[11:0] : arx_s_q[11:0];
    dvs     = pass_q ? arx_s_q[11:0] : ary_s_q[11:0];
    add_t   = mul_b[cnt_q[3:0]] ? ({12'd0, mul_a} << cnt_q) : 24'd0;
    rem_sh  = {rem_q[11:0], prod_q[23]};
    ge      = rem_sh >= {1'b0, dvs};
    quo     = {prod_q[22:0], ge};
    wc      = sat12(prod_q);
    w_min   = (w_q > w_s_q) ? w_s_q : w_q;
    h_min   = (h_q > h_s_q) ? h_s_q : h_q;
    hdiff   = w_s_q - w_q;
    vdiff   = h_s_q - h_q;
    hmin_c  = (w_s_q > w_q) ? {1'b0, hdiff[11:1]} : 12'd0;
    vmin_c  = (h_s_q > h_q) ? {1'b0, vdiff[11:1]} : 12'd0;
  end

  always_comb begin
    state_d  = state_q;
    w_s_d    = w_s_q;
    h_s_d    = h_s_q;
    arx_s_d  = arx_s_q;
    ary_s_d  = ary_s_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    w_d      = w_q;
    h_d      = h_q;
    hmin_c_d = hmin_c_q;
    hmax_c_d = hmax_c_q;
    vmin_c_d = vmin_c_q;
    vmax_c_d = vmax_c_q;
    hmin_d   = hmin_q;
    hmax_d   = hmax_q;
    vmin_d   = vmin_q;
    vmax_d   = vmax_q;
    valid_d  = valid_q;
    upd_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (changed || !valid_q) state_d = S_LATCH;
      end
      S_LATCH: begin
        w_s_d   = vw.HDMI_WIDTH;
        h_s_d   = vw.HDMI_HEIGHT;
        arx_s_d = vw.ARX;
        ary_s_d = vw.ARY;
        cnt_d   = 5'd0;
        pass_d  = 1'b0;
        prod_d  = 24'd0;
        if (vw.ARX[12]) begin
          w_d = (vw.ARX[11:0] == 12'd0) ? vw.HDMI_WIDTH : vw.ARX[11:0];
          h_d = (vw.ARY[11:0] == 12'd0) ? vw.HDMI_HEIGHT : vw.ARY[11:0];
          state_d = S_CLAMP;
        end else if (vw.ARX[11:0] == 12'd0 || vw.ARY[11:0] == 12'd0) begin
          w_d = vw.HDMI_WIDTH;
          h_d = vw.HDMI_HEIGHT;
          state_d = S_CLAMP;
        end else begin
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        prod_d = prod_q + add_t;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd11) begin
          cnt_d   = 5'd0;
          rem_d   = 13'd0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d  = ge ? (rem_sh - {1'b0, dvs}) : rem_sh;
        prod_d = quo;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd23) begin
          cnt_d = 5'd0;
          if (pass_q) begin
            w_d     = w_s_q;
            h_d     = sat12(quo);
            state_d = S_CLAMP;
          end else begin
            state_d = S_CMP;
          end
        end
      end
      S_CMP: begin
        if (wc <= w_s_q) begin
          w_d     = wc;
          h_d     = h_s_q;
          state_d = S_CLAMP;
        end else begin
          pass_d  = 1'b1;
          prod_d  = 24'd0;
          cnt_d   = 5'd0;
          state_d = S_MUL;
        end
      end
      S_CLAMP: begin
        w_d     = (w_min == 12'd0) ? 12'd1 : w_min;
        h_d     = (h_min == 12'd0) ? 12'd1 : h_min;
        state_d = S_CENTER;
      end
      S_CENTER: begin
        hmin_c_d = hmin_c;
        hmax_c_d = hmin_c + w_q - 12'd1;
        vmin_c_d = vmin_c;
        vmax_c_d = vmin_c + h_q - 12'd1;
        state_d  = S_PUBLISH;
      end
      S_PUBLISH: begin
        if (!changed) begin
          hmin_d  = hmin_c_q;
          hmax_d  = hmax_c_q;
          vmin_d  = vmin_c_q;
          vmax_d  = vmax_c_q;
          valid_d = 1'b1;
          upd_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inputs moved under an active calculation: restart from a fresh snapshot.
    if (state_q != S_IDLE && state_q != S_LATCH && changed) begin
      state_d = S_LATCH;
    end
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      state_q  <= S_IDLE;
      w_s_q    <= '0;
      h_s_q    <= '0;
      arx_s_q  <= '0;
      ary_s_q  <= '0;
      cnt_q    <= '0;
      pass_q   <= 1'b0;
      prod_q   <= '0;
      rem_q    <= '0;
      w_q      <= '0;
      h_q      <= '0;
      hmin_c_q <= '0;
      hmax_c_q <= '0;
      vmin_c_q <= '0;
      vmax_c_q <= '0;
      hmin_q   <= '0;
      hmax_q   <= '0;
      vmin_q   <= '0;
      vmax_q   <= '0;
      valid_q  <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_s_q    <= w_s_d;
      h_s_q    <= h_s_d;
      arx_s_q  <= arx_s_d;
      ary_s_q  <= ary_s_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      w_q      <= w_d;
      h_q      <= h_d;
      hmin_c_q <= hmin_c_d;
      hmax_c_q <= hmax_c_d;
      vmin_c_q <= vmin_c_d;
      vmax_c_q <= vmax_c_d;
      hmin_q   <= hmin_d;
      hmax_q   <= hmax_d;
      vmin_q   <= vmin_d;
      vmax_q   <= vmax_d;
      valid_q  <= valid_d;
      upd_q    <= upd_d;
    end
  end

  assign vw.hmin  = hmin_q;
  assign vw.hmax  = hmax_q;
  assign vw.vmin  = vmin_q;
  assign vw.vmax  = vmax_q;
  assign vw.valid = valid_q;
  assign vw.upd   = upd_q;

endmodule

// File: tb/tb_video_window_calc.sv
// Bench for video_window_calc: directed cases plus randomized
// inputs checked against an arithmetic window model.
module tb_video_window_calc;

  logic clk = 1'b0;
  logic reset;
  int   npass = 0;
  int   ntotal = 0;

  always #5 clk = ~clk;

  video_window_calc_if vw();

  video_window_calc dut (
    .CLK_VIDEO (clk),
    .reset     (reset),
    .vw        (vw)
  );

  function automatic logic [47:0] model(input int W, H, arx, ary);
    int ax, ay, w, h, wc, hmin, vmin;
    ax = arx % 4096;
    ay = ary % 4096;
    if (arx >= 4096) begin
      w = (ax != 0) ? ax : W;
      h = (ay != 0) ? ay : H;
    end else if (ax == 0 || ay == 0) begin
      w = W;
      h = H;
    end else begin
      wc = (H * ax) / ay;
      if (wc > 4095) wc = 4095;
      if (wc <= W) begin
        w = wc;
        h = H;
      end else begin
        w = W;
        h = (W * ay) / ax;
        if (h > 4095) h = 4095;
      end
    end
    if (w > W) w = W;
    if (h > H) h = H;
    if (w == 0) w = 1;
    if (h == 0) h = 1;
    hmin = (W > w) ? (W - w) / 2 : 0;
    vmin = (H > h) ? (H - h) / 2 : 0;
    return {12'(hmin), 12'(hmin + w - 1), 12'(vmin), 12'(vmin + h - 1)};
  endfunction

  function automatic logic [47:0] win();
    return {vw.hmin, vw.hmax, vw.vmin, vw.vmax};
  endfunction

  task automatic apply(input int W, H, arx, ary);
    vw.HDMI_WIDTH  = 12'(W);
    vw.HDMI_HEIGHT = 12'(H);
    vw.ARX         = 13'(arx);
    vw.ARY         = 13'(ary);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_upd(input int budget, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < budget && !seen) begin
      tick();
      cyc++;
      if (vw.upd) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply(1920, 1080, 4, 3);
    repeat (3) tick();
    ntotal++;
    if (win() !== 48'd0)
      $display("FAIL reset_win got %h want 0", win());
    else npass++;
    ntotal++;
    if (vw.valid !== 1'b0 || vw.upd !== 1'b0)
      $display("FAIL reset_flags got valid=%b upd=%b want 0 0", vw.valid, vw.upd);
    else npass++;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    int W[5]   = '{1920, 1920, 1920, 1280, 1920};
    int H[5]   = '{1080, 1080, 1080, 720, 1080};
    int AX[5]  = '{4, 64, 'h1500, 0, 'h17D0};
    int AY[5]  = '{3, 9, 'h13C0, 7, 'h1000};
    int LAT[5] = '{81, 81, 7, 7, 7};
    logic [47:0] exp[5];
    int cyc;
    bit seen;
    exp[0] = {12'd240, 12'd1679, 12'd0, 12'd1079};
    exp[1] = {12'd0, 12'd1919, 12'd405, 12'd674};
    exp[2] = {12'd320, 12'd1599, 12'd60, 12'd1019};
    exp[3] = {12'd0, 12'd1279, 12'd0, 12'd719};
    exp[4] = {12'd0, 12'd1919, 12'd0, 12'd1079};
    for (int i = 0; i < 5; i++) begin
      apply(W[i], H[i], AX[i], AY[i]);
      wait_upd(120, cyc, seen);
      ntotal++;
      if (!seen || cyc > LAT[i])
        $display("FAIL dir%0d_latency got %0d cycles seen=%b want <=%0d", i, cyc, seen, LAT[i]);
      else npass++;
      ntotal++;
      if (win() !== exp[i] || vw.valid !== 1'b1)
        $display("FAIL dir%0d_window got %h valid=%b want %h valid=1", i, win(), vw.valid, exp[i]);
      else npass++;
      tick();
      ntotal++;
      if (vw.upd !== 1'b0)
        $display("FAIL dir%0d_upd_width got %b want 0", i, vw.upd);
      else npass++;
    end
  endtask

  task automatic test_abort();
    logic [47:0] prior;
    logic [47:0] exp;
    bit held;
    int nupd, cyc_first;
    prior     = win();
    exp       = {12'd420, 12'd1499, 12'd0, 12'd1079};
    held      = 1'b1;
    nupd      = 0;
    cyc_first = 0;
    apply(1920, 1080, 4, 3);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vw.upd) nupd++;
      if (win() !== prior) held = 1'b0;
    end
    apply(1920, 1080, 4, 4);
    for (int i = 1; i <= 120; i++) begin
      tick();
      if (vw.upd) begin
        nupd++;
        if (cyc_first == 0) cyc_first = i;
      end
      if (nupd == 0 && win() !== prior) held = 1'b0;
    end
    ntotal++;
    if (!held)
      $display("FAIL abort_hold got changed window before upd want held %h", prior);
    else npass++;
    ntotal++;
    if (nupd != 1)
      $display("FAIL abort_upd_count got %0d want 1", nupd);
    else npass++;
    ntotal++;
    if (win() !== exp)
      $display("FAIL abort_window got %h want %h", win(), exp);
    else npass++;
    ntotal++;
    if (cyc_first == 0 || cyc_first > 81)
      $display("FAIL abort_latency got %0d want 1..81", cyc_first);
    else npass++;
  endtask

  task automatic test_reset_mid();
    logic [47:0] exp;
    int nupd;
    exp  = {12'd0, 12'd1279, 12'd152, 12'd871};
    nupd = 0;
    apply(1280, 1024, 16, 9);
    repeat (25) tick();
    reset = 1'b1;
    tick();
    ntotal++;
    if (win() !== 48'd0 || vw.valid !== 1'b0 || vw.upd !== 1'b0)
      $display("FAIL midreset_state got %h valid=%b upd=%b want 0", win(), vw.valid, vw.upd);
    else npass++;
    reset = 1'b0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (vw.upd) nupd++;
    end
    ntotal++;
    if (nupd != 1)
      $display("FAIL midreset_upd_count got %0d want 1", nupd);
    else npass++;
    ntotal++;
    if (win() !== exp || vw.valid !== 1'b1)
      $display("FAIL midreset_window got %h valid=%b want %h valid=1", win(), vw.valid, exp);
    else npass++;
  endtask

  task automatic test_zero_size();
    int cyc;
    bit seen;
    apply(0, 0, 4, 3);
    wait_upd(120, cyc, seen);
    ntotal++;
    if (!seen || win() !== 48'd0)
      $display("FAIL zero_wh got %h seen=%b want 0", win(), seen);
    else npass++;
    apply(0, 600, 0, 5);
    wait_upd(120, cyc, seen);
    ntotal++;
    if (!seen || win() !== {12'd0, 12'd0, 12'd0, 12'd599})
      $display("FAIL zero_w got %h seen=%b want %h", win(), seen,
               {12'd0, 12'd0, 12'd0, 12'd599});
    else npass++;
  endtask

  task automatic test_back_to_back();
    logic [47:0] exp;
    logic [47:0] hold;
    int nupd;
    bit stable;
    nupd = 0;
    apply(1600, 1200, 16, 10);
    repeat (3) tick();
    apply(1600, 1200, 5, 4);
    exp = model(1600, 1200, 5, 4);
    for (int i = 0; i < 110; i++) begin
      tick();
      if (vw.upd) nupd++;
    end
    ntotal++;
    if (nupd != 1)
      $display("FAIL b2b_upd_count got %0d want 1", nupd);
    else npass++;
    ntotal++;
    if (win() !== exp)
      $display("FAIL b2b_window got %h want %h", win(), exp);
    else npass++;
    hold   = win();
    stable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (vw.upd || win() !== hold) stable = 1'b0;
    end
    ntotal++;
    if (!stable)
      $display("FAIL b2b_stable got activity with unchanged inputs want none");
    else npass++;
  endtask

  task automatic test_random();
    int W, H, ax, ay, mode, cyc;
    bit seen;
    logic [47:0] exp;
    for (int n = 0; n < 30; n++) begin
      W    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 16) : $urandom_range(256, 4095);
      H    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 16) : $urandom_range(256, 4095);
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        ax = 4096 + (($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4095));
        ay = 4096 + (($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4095));
      end else if (mode == 1) begin
        ax = $urandom_range(0, 1) ? 0 : $urandom_range(1, 4095);
        ay = (ax == 0) ? $urandom_range(0, 4095) : 0;
      end else if (mode == 2) begin
        ax = $urandom_range(1, 64);
        ay = $urandom_range(1, 64);
      end else begin
        ax = $urandom_range(1, 4095);
        ay = $urandom_range(1, 4095);
      end
      if ({12'(W), 12'(H), 13'(ax), 13'(ay)}
          == {vw.HDMI_WIDTH, vw.HDMI_HEIGHT, vw.ARX, vw.ARY})
        W = W ^ 1;
      apply(W, H, ax, ay);
      exp = model(W, H, ax, ay);
      wait_upd(120, cyc, seen);
      ntotal++;
      if (!seen || cyc > 81)
        $display("FAIL rand%0d_latency got %0d seen=%b want <=81", n, cyc, seen);
      else npass++;
      ntotal++;
      if (win() !== exp)
        $display("FAIL rand%0d_window W=%0d H=%0d ARX=%h ARY=%h got %h want %h",
                 n, W, H, ax, ay, win(), exp);
      else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_reset_mid();
    test_zero_size();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
